// File: rtl/control_pipe.sv
// control_pipe: RV32I opcode decoder feeding an ID/EX -> EX/MEM -> MEM/WB
// control pipeline, with load-use hazard detection and branch/jump flush.
// Optional feature macro: CONTROL_PIPE_ILLEGAL_EN (flags unknown opcodes in
// bit 12 of the control word and on illegal_o when the word reaches EX).
module control_pipe #(
  parameter int unsigned CTRL_WIDTH = 16,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [6:0]            opcode_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [CTRL_WIDTH-1:0] ctrl_ex_o,
  output logic [CTRL_WIDTH-1:0] ctrl_mem_o,
  output logic [CTRL_WIDTH-1:0] ctrl_wb_o,
  output logic [REG_ADDR_W-1:0] rd_ex_o,
  output logic [REG_ADDR_W-1:0] rd_mem_o,
  output logic [REG_ADDR_W-1:0] rd_wb_o,
  output logic                  illegal_o
);

  // Meaningful decoded bits; anything above is zero-extended.
  localparam int unsigned DEC_W = 13;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Control word bit positions.
  localparam int unsigned B_MEM2REG = 0;
  localparam int unsigned B_REGWR   = 1;
  localparam int unsigned B_MEMWE   = 2;
  localparam int unsigned B_MEMRE   = 3;
  localparam int unsigned B_BRANCH  = 4;
  localparam int unsigned B_ALUSRC  = 5;
  localparam int unsigned B_ALUOP   = 6;
  localparam int unsigned B_JAL     = 8;
  localparam int unsigned B_JALR    = 9;
  localparam int unsigned B_LUI     = 10;
  localparam int unsigned B_AUIPC   = 11;
  localparam int unsigned B_ILLEGAL = 12;

  logic [DEC_W-1:0]      w_dec;
  logic [CTRL_WIDTH-1:0] w_ctrl_dec;
  logic                  w_rs1_used;
  logic                  w_rs2_used;
  logic                  w_stall;
  logic                  w_bubble;

  logic [CTRL_WIDTH-1:0] r_ctrl_ex;
  logic [CTRL_WIDTH-1:0] r_ctrl_mem;
  logic [CTRL_WIDTH-1:0] r_ctrl_wb;
  logic [REG_ADDR_W-1:0] r_rd_ex;
  logic [REG_ADDR_W-1:0] r_rd_mem;
  logic [REG_ADDR_W-1:0] r_rd_wb;

  // ID-stage decode: control word plus which source registers are read.
  always_comb begin
    w_dec      = '0;
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        w_dec[B_REGWR]            = 1'b1;
        w_dec[B_ALUSRC]           = 1'b1;
        w_dec[B_ALUOP+1:B_ALUOP]  = 2'b10;
        w_rs1_used                = 1'b1;
        w_rs2_used                = 1'b1;
      end
      OP_ITYPE: begin
        w_dec[B_REGWR]            = 1'b1;
        w_dec[B_ALUOP+1:B_ALUOP]  = 2'b10;
        w_rs1_used                = 1'b1;
      end
      OP_LOAD: begin
        w_dec[B_MEMRE]            = 1'b1;
        w_dec[B_REGWR]            = 1'b1;
        w_dec[B_MEM2REG]          = 1'b1;
        w_rs1_used                = 1'b1;
      end
      OP_STORE: begin
        w_dec[B_MEMWE]            = 1'b1;
        w_rs1_used                = 1'b1;
        w_rs2_used                = 1'b1;
      end
      OP_BRANCH: begin
        w_dec[B_BRANCH]           = 1'b1;
        w_dec[B_ALUSRC]           = 1'b1;
        w_dec[B_ALUOP+1:B_ALUOP]  = 2'b01;
        w_rs1_used                = 1'b1;
        w_rs2_used                = 1'b1;
      end
      OP_JAL: begin
        w_dec[B_JAL]              = 1'b1;
        w_dec[B_REGWR]            = 1'b1;
      end
      OP_JALR: begin
        w_dec[B_JALR]             = 1'b1;
        w_dec[B_REGWR]            = 1'b1;
        w_rs1_used                = 1'b1;
      end
      OP_LUI: begin
        w_dec[B_LUI]              = 1'b1;
        w_dec[B_REGWR]            = 1'b1;
      end
      OP_AUIPC: begin
        w_dec[B_AUIPC]            = 1'b1;
        w_dec[B_REGWR]            = 1'b1;
      end
      default: begin
`ifdef CONTROL_PIPE_ILLEGAL_EN
        w_dec[B_ILLEGAL]          = valid_i;
`else
        w_dec                     = '0;
`endif
      end
    endcase
    // x0 is never written; jump flags still needed for PC redirect.
    if (rd_i == '0) begin
      w_dec[B_REGWR] = 1'b0;
    end
  end

  assign w_ctrl_dec = CTRL_WIDTH'(w_dec);

  // Load-use hazard: the load in EX writes a register the ID instruction reads.
  assign w_stall = valid_i & ~flush_i & r_ctrl_ex[B_MEMRE] & (r_rd_ex != '0) &
                   ((w_rs1_used & (rs1_i == r_rd_ex)) |
                    (w_rs2_used & (rs2_i == r_rd_ex)));

  assign w_bubble = flush_i | w_stall | ~valid_i;

  // Pipeline registers; EX takes a bubble on flush/stall/invalid, MEM/WB always advance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl_ex  <= '0;
      r_ctrl_mem <= '0;
      r_ctrl_wb  <= '0;
      r_rd_ex    <= '0;
      r_rd_mem   <= '0;
      r_rd_wb    <= '0;
    end else begin
      r_ctrl_ex  <= w_bubble ? '0 : w_ctrl_dec;
      r_rd_ex    <= w_bubble ? '0 : rd_i;
      r_ctrl_mem <= r_ctrl_ex;
      r_rd_mem   <= r_rd_ex;
      r_ctrl_wb  <= r_ctrl_mem;
      r_rd_wb    <= r_rd_mem;
    end
  end

  assign stall_o    = w_stall;
  assign ctrl_ex_o  = r_ctrl_ex;
  assign ctrl_mem_o = r_ctrl_mem;
  assign ctrl_wb_o  = r_ctrl_wb;
  assign rd_ex_o    = r_rd_ex;
  assign rd_mem_o   = r_rd_mem;
  assign rd_wb_o    = r_rd_wb;

`ifdef CONTROL_PIPE_ILLEGAL_EN
  assign illegal_o = r_ctrl_ex[B_ILLEGAL];
`else
  assign illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed and randomized checks of control_pipe against a
// stage-array reference model built from the opcode table.
module tb_control_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [6:0]  opcode_i;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic        flush_i;
  logic        stall_o;
  logic [15:0] ctrl_ex_o, ctrl_mem_o, ctrl_wb_o;
  logic [4:0]  rd_ex_o, rd_mem_o, rd_wb_o;
  logic        illegal_o;

  control_pipe #(.CTRL_WIDTH(16), .REG_ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .opcode_i(opcode_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
    .stall_o(stall_o), .ctrl_ex_o(ctrl_ex_o), .ctrl_mem_o(ctrl_mem_o),
    .ctrl_wb_o(ctrl_wb_o), .rd_ex_o(rd_ex_o), .rd_mem_o(rd_mem_o),
    .rd_wb_o(rd_wb_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [6:0] RTYPE = 7'b0110011, ITYPE = 7'b0010011, LOAD = 7'b0000011,
                         STORE = 7'b0100011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;
  logic [6:0] legal_ops [9] = '{RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC};

  int n_cmp = 0;
  int n_err = 0;

  // Reference pipeline: index 0 = EX, 1 = MEM, 2 = WB.
  logic [15:0] m_word [3];
  logic [4:0]  m_rd   [3];
  logic        last_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Control word from the opcode table, assembled by field weights.
  function automatic logic [15:0] ref_word(input logic [6:0] op, input logic [4:0] rd, input logic v);
    int mtr = 0, wr = 0, we = 0, re = 0, br = 0, src = 0, aop = 0;
    int jal = 0, jalr = 0, lui = 0, auipc = 0, ill = 0;
    case (op)
      RTYPE:  begin wr = 1; src = 1; aop = 2; end
      ITYPE:  begin wr = 1; aop = 2; end
      LOAD:   begin re = 1; wr = 1; mtr = 1; end
      STORE:  we = 1;
      BRANCH: begin br = 1; src = 1; aop = 1; end
      JAL:    begin jal = 1; wr = 1; end
      JALR:   begin jalr = 1; wr = 1; end
      LUI:    begin lui = 1; wr = 1; end
      AUIPC:  begin auipc = 1; wr = 1; end
      default: begin
`ifdef CONTROL_PIPE_ILLEGAL_EN
        ill = v ? 1 : 0;
`else
        ill = 0;
`endif
      end
    endcase
    if (rd == 5'd0) wr = 0;
    return 16'(mtr + 2*wr + 4*we + 8*re + 16*br + 32*src + 64*aop +
               256*jal + 512*jalr + 1024*lui + 2048*auipc + 4096*ill);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] op);
    return (op == RTYPE) || (op == ITYPE) || (op == LOAD) || (op == STORE) ||
           (op == BRANCH) || (op == JALR);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    return (op == RTYPE) || (op == STORE) || (op == BRANCH);
  endfunction

  // One clock: drive at negedge, check the stall, advance model, check stages.
  task automatic step(input logic rst, input logic v, input logic [6:0] op,
                      input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                      input logic fl);
    logic exp_stall;
    logic ex_is_load;
    @(negedge clk_i);
    rst_i = rst; valid_i = v; opcode_i = op; rs1_i = r1; rs2_i = r2; rd_i = rd; flush_i = fl;
    #1;
    ex_is_load = m_word[0][3];
    exp_stall  = v && !fl && ex_is_load && (m_rd[0] != 5'd0) &&
                 ((reads_rs1(op) && r1 == m_rd[0]) || (reads_rs2(op) && r2 == m_rd[0]));
    check("stall_o", 32'(stall_o), 32'(exp_stall));
    last_stall = stall_o;
    @(posedge clk_i);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin m_word[i] = '0; m_rd[i] = '0; end
    end else begin
      m_word[2] = m_word[1]; m_rd[2] = m_rd[1];
      m_word[1] = m_word[0]; m_rd[1] = m_rd[0];
      if (!v || fl || exp_stall) begin
        m_word[0] = '0; m_rd[0] = '0;
      end else begin
        m_word[0] = ref_word(op, rd, v); m_rd[0] = rd;
      end
    end
    #1;
    check("ctrl_ex",   32'(ctrl_ex_o),  32'(m_word[0]));
    check("ctrl_mem",  32'(ctrl_mem_o), 32'(m_word[1]));
    check("ctrl_wb",   32'(ctrl_wb_o),  32'(m_word[2]));
    check("rd_ex",     32'(rd_ex_o),    32'(m_rd[0]));
    check("rd_mem",    32'(rd_mem_o),   32'(m_rd[1]));
    check("rd_wb",     32'(rd_wb_o),    32'(m_rd[2]));
    check("illegal_o", 32'(illegal_o),  32'(m_word[0][12]));
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; opcode_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0; flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin m_word[i] = '0; m_rd[i] = '0; end
    repeat (2) @(posedge clk_i);

    // Reset held two cycles while an RTYPE is fed; word enters EX only after release.
    step(1'b1, 1'b1, RTYPE, 5'd1, 5'd2, 5'd4, 1'b0);
    check("rst_ex", 32'(ctrl_ex_o), 32'h0);
    step(1'b1, 1'b1, RTYPE, 5'd1, 5'd2, 5'd4, 1'b0);
    check("rst_wb", 32'(ctrl_wb_o), 32'h0);
    step(1'b0, 1'b1, RTYPE, 5'd1, 5'd2, 5'd4, 1'b0);
    check("post_rst_ex", 32'(ctrl_ex_o), 32'h0A2);
    nop(); nop(); nop();

    // Pipelined decode: LOAD then RTYPE, LOAD reaches WB after 3 cycles.
    step(1'b0, 1'b1, LOAD,  5'd0, 5'd0, 5'd5, 1'b0);
    check("load_ex", 32'(ctrl_ex_o), 32'h00B);
    step(1'b0, 1'b1, RTYPE, 5'd1, 5'd2, 5'd6, 1'b0);
    check("rtype_ex", 32'(ctrl_ex_o), 32'h0A2);
    nop();
    check("load_wb", 32'(ctrl_wb_o), 32'h00B);
    check("load_rd_wb", 32'(rd_wb_o), 32'd5);

    // Load-use on rs1: one stall cycle, bubble, then the ITYPE.
    step(1'b0, 1'b1, LOAD,  5'd0, 5'd0, 5'd5, 1'b0);
    step(1'b0, 1'b1, ITYPE, 5'd5, 5'd0, 5'd9, 1'b0);
    check("lu_stall", 32'(last_stall), 32'd1);
    check("lu_bubble", 32'(ctrl_ex_o), 32'h0);
    step(1'b0, 1'b1, ITYPE, 5'd5, 5'd0, 5'd9, 1'b0);
    check("lu_release", 32'(last_stall), 32'd0);
    check("lu_itype_ex", 32'(ctrl_ex_o), 32'h082);

    // Load to x0 never causes a stall.
    step(1'b0, 1'b1, LOAD,  5'd0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b1, ITYPE, 5'd0, 5'd0, 5'd9, 1'b0);
    check("x0_nostall", 32'(last_stall), 32'd0);

    // rs2 field only matters for instructions that read rs2.
    step(1'b0, 1'b1, LOAD,  5'd0, 5'd0, 5'd7, 1'b0);
    step(1'b0, 1'b1, ITYPE, 5'd0, 5'd7, 5'd9, 1'b0);
    check("itype_rs2_nostall", 32'(last_stall), 32'd0);
    step(1'b0, 1'b1, LOAD,  5'd0, 5'd0, 5'd7, 1'b0);
    step(1'b0, 1'b1, STORE, 5'd0, 5'd7, 5'd0, 1'b0);
    check("store_rs2_stall", 32'(last_stall), 32'd1);
    step(1'b0, 1'b1, STORE, 5'd0, 5'd7, 5'd0, 1'b0);
    check("store_ex", 32'(ctrl_ex_o), 32'h004);

    // Flush overrides the hazard: single bubble, load keeps moving.
    step(1'b0, 1'b1, LOAD,   5'd0, 5'd0, 5'd3, 1'b0);
    step(1'b0, 1'b1, BRANCH, 5'd3, 5'd0, 5'd0, 1'b1);
    check("flush_nostall", 32'(last_stall), 32'd0);
    check("flush_bubble", 32'(ctrl_ex_o), 32'h0);
    check("flush_load_mem", 32'(ctrl_mem_o), 32'h00B);

    // Unknown opcode.
    step(1'b0, 1'b1, 7'b1111111, 5'd1, 5'd1, 5'd1, 1'b0);
`ifdef CONTROL_PIPE_ILLEGAL_EN
    check("illegal_ex", 32'(ctrl_ex_o), 32'h1000);
    check("illegal_pulse", 32'(illegal_o), 32'd1);
`else
    check("illegal_ex", 32'(ctrl_ex_o), 32'h0);
    check("illegal_off", 32'(illegal_o), 32'd0);
`endif
    nop();
    check("illegal_drop", 32'(illegal_o), 32'd0);
    step(1'b0, 1'b1, 7'b1111111, 5'd1, 5'd1, 5'd1, 1'b1);
    check("illegal_flushed", 32'(illegal_o), 32'd0);
    nop(); nop(); nop();

    // Randomized traffic with small register indices to provoke hazards.
    for (int n = 0; n < 2000; n++) begin
      logic [6:0] op;
      int k;
      k  = int'($urandom_range(0, 9));
      op = (k == 9) ? 7'($urandom) : legal_ops[k];
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), op,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
